stream_sorter_p: RTL and testbench
==================================

Name: stream_sorter_p

Overview:
- Parametrised successor to the fixed 8-bit, 256-entry streaming sorter.
- Accepts a frame of up to DEPTH keys, each with an attached tag, on a valid/ready input stream and inserts each word into a sorted register array in one cycle.
- Once the frame closes, it emits the frame in sorted order on a valid/last output stream.
- Adds configurable key/tag width, depth, per-frame ascending/descending mode, early frame termination and input back-pressure.

Parameters:
- DATA_W, 8, key width in bits.
- TAG_W, 8, payload width carried with each key (not compared).
- DEPTH, 256, maximum words per frame (>=2).
- CNT_W, $clog2(DEPTH+1), occupancy counter width.

Ports:
- clk  in  1  system clock, rising edge.
- xrst  in  1  asynchronous active-low reset.
- data_in  in  DATA_W  input key.
- tag_in  in  TAG_W  input payload.
- valid_in  in  1  input word present.
- last_in  in  1  qualifies final word of a short frame.
- descend  in  1  order for the frame: 0 ascending, 1 descending.
- ready_in  out  1  block can accept a word.
- data_out  out  DATA_W  sorted key.
- tag_out  out  TAG_W  payload travelling with data_out.
- valid_out  out  1  output word valid; no output back-pressure.
- last_out  out  1  final word of the output frame.

Behaviour:
- Reset (xrst low, asynchronous) clears:
  - occupancy count to 0 and array contents to 0;
  - state to FILL and mode register to 0;
  - ready_in to 1;
  - valid_out, last_out, data_out and tag_out to 0.
- Reset asserted mid-frame discards all stored data. The first accepted word after release starts a new frame.
- Accept rule: a word is taken on a rising edge where valid_in && ready_in. With ready_in low, valid_in is ignored and no state changes.
- State FILL (ready_in=1):
  - descend is latched on the first accepted word of a frame and held for the whole frame; descend on later words is ignored.
  - Insertion into array[0..cnt-1]:
    - Ascending: new word goes after every stored key <= data_in.
    - Descending: new word goes after every stored key >= data_in.
    - Larger-index entries shift up one place.
    - Result: equal keys leave in arrival order (stable sort).
  - cnt increments on each accept.
  - Frame closes on the accept where last_in=1 or cnt reaches DEPTH.
  - On that edge: state goes to DRAIN and ready_in drops to 0.
- State DRAIN (ready_in=0):
  - First output edge is the rising edge following the closing accept.
  - From that edge, valid_out=1 for exactly F consecutive cycles (F = frame length, 1..DEPTH).
  - Each cycle data_out/tag_out = array[0], then the array shifts down one place.
  - last_out=1 only with the F-th word.
  - On the edge after the F-th word: valid_out and last_out drop to 0, cnt goes to 0, state returns to FILL, ready_in rises.
- Latency: 1 cycle from the closing accept to the first valid output.
- Throughput: 2F+1 cycles per frame. No overlap of fill and drain.
- Outputs are registered. data_out/tag_out hold their last value when valid_out=0.
- Boundaries:
  - F=1 frame: single output word with valid_out=1 and last_out=1.
  - last_in on the DEPTH-th word: same as a full frame; no extra close.
  - last_in with valid_in=0: ignored.
  - All-equal keys: output in arrival order by tag.
  - Keys 0 and 2^DATA_W-1 compare as unsigned.

Test Plan:
- 256 random 8-bit keys, tag=index, descend=0, no gaps -> ready_in falls after 256 accepts, valid_out rises 1 cycle later, 256 ascending keys, last_out on word 255, ready_in high on the following edge.
- Same stimulus with descend=1 on word 0 and descend toggled on later words -> strictly non-increasing output throughout; later toggles have no effect.
- Frame of 5 words (keys 9,3,7,3,1; tags 0..4) with last_in on word 4 -> output keys 1,3,3,7,9 with tags 4,1,3,2,0; last_out on the 5th word; valid_out high exactly 5 cycles.
- valid_in held high through DRAIN with changing data -> none of those words captured. The next frame contains only words offered after ready_in returns high.
- Single-word frame (key 0xAA, last_in=1) -> one output cycle, data_out=0xAA, valid_out=1, last_out=1.
- xrst pulsed low after 100 accepts -> valid_out/ready_in immediately 0/1. The next 4-word frame (last_in on word 3) outputs only those 4 words, sorted.

Source files
------------

// File: rtl/stream_sorter_p_if.sv
// Stream bundle for the sorter: the input word/handshake stream and the
// sorted valid/last output stream. The sorter takes the slave side and the
// producer/consumer takes the master side.
interface stream_sorter_p_if #(
    parameter int DATA_W = 8,
    parameter int TAG_W  = 8
);
    logic [DATA_W-1:0] data_in;
    logic [TAG_W-1:0]  tag_in;
    logic              valid_in;
    logic              last_in;
    logic              descend;
    logic              ready_in;
    logic [DATA_W-1:0] data_out;
    logic [TAG_W-1:0]  tag_out;
    logic              valid_out;
    logic              last_out;

    modport master (
        output data_in, tag_in, valid_in, last_in, descend,
        input  ready_in, data_out, tag_out, valid_out, last_out
    );

    modport slave (
        input  data_in, tag_in, valid_in, last_in, descend,
        output ready_in, data_out, tag_out, valid_out, last_out
    );
endinterface

// File: rtl/stream_sorter_p.sv
// Streaming insertion sorter. Words of a frame are inserted one per cycle
// into a sorted register array (stable: equal keys keep arrival order).
// When the frame closes the array is drained front-first, one word per
// cycle, with last_out flagging the final word. Fill and drain never overlap.
module stream_sorter_p #(
    parameter int DATA_W = 8,
    parameter int TAG_W  = 8,
    parameter int DEPTH  = 256,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              xrst,
    stream_sorter_p_if.slave  bus
);

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              mode_q;
    logic              mode_d;

    logic [DATA_W-1:0] key_q [DEPTH];
    logic [DATA_W-1:0] key_d [DEPTH];
    logic [TAG_W-1:0]  tag_q [DEPTH];
    logic [TAG_W-1:0]  tag_d [DEPTH];

    logic [DEPTH-1:0]  stays;
    logic              desc_eff;
    logic              accept;
    logic              emit;
    logic              valid_d;
    logic              last_d;

    logic [DATA_W-1:0] data_out_q;
    logic [TAG_W-1:0]  tag_out_q;
    logic              valid_out_q;
    logic              last_out_q;

    // The block only listens while filling, so readiness follows the state register.
    assign bus.ready_in  = (state_q == FILL);
    assign bus.data_out  = data_out_q;
    assign bus.tag_out   = tag_out_q;
    assign bus.valid_out = valid_out_q;
    assign bus.last_out  = last_out_q;

    // On the first word of a frame the mode register is still stale, so use descend directly.
    assign desc_eff = (cnt_q == '0) ? bus.descend : mode_q;

    // Mark the occupied entries that stay below the incoming key; this is always a prefix.
    always_comb begin
        stays = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < cnt_q) begin
                if (desc_eff) begin
                    stays[i] = (key_q[i] >= bus.data_in);
                end else begin
                    stays[i] = (key_q[i] <= bus.data_in);
                end
            end
        end
    end

    // Next state, counter, mode latch and output strobes of the fill/drain sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        accept  = 1'b0;
        emit    = 1'b0;
        valid_d = 1'b0;
        last_d  = 1'b0;
        case (state_q)
            FILL: begin
                if (bus.valid_in) begin
                    accept = 1'b1;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == '0) begin
                        mode_d = bus.descend;
                    end
                    if (bus.last_in || (cnt_q == CNT_W'(DEPTH - 1))) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (cnt_q != '0) begin
                    emit    = 1'b1;
                    valid_d = 1'b1;
                    last_d  = (cnt_q == CNT_W'(1));
                    cnt_d   = cnt_q - CNT_W'(1);
                end else begin
                    state_d = FILL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // Array update: insert-and-shift-up while filling, shift-down while draining.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            key_d[i] = key_q[i];
            tag_d[i] = tag_q[i];
        end
        if (accept) begin
            if (!stays[0]) begin
                key_d[0] = bus.data_in;
                tag_d[0] = bus.tag_in;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (!stays[i]) begin
                    if (stays[i-1]) begin
                        key_d[i] = bus.data_in;
                        tag_d[i] = bus.tag_in;
                    end else begin
                        key_d[i] = key_q[i-1];
                        tag_d[i] = tag_q[i-1];
                    end
                end
            end
        end else if (emit) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                key_d[i] = key_q[i+1];
                tag_d[i] = tag_q[i+1];
            end
            key_d[DEPTH-1] = '0;
            tag_d[DEPTH-1] = '0;
        end
    end

    // Sequencer state register with its counter and frame order latch.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state_q <= FILL;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    // Sorted storage; a reset throws away whatever frame was in progress.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            for (int i = 0; i < DEPTH; i++) begin
                key_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                key_q[i] <= key_d[i];
                tag_q[i] <= tag_d[i];
            end
        end
    end

    // Registered output stream; data and tag hold their last value between words.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            data_out_q  <= '0;
            tag_out_q   <= '0;
            valid_out_q <= 1'b0;
            last_out_q  <= 1'b0;
        end else begin
            valid_out_q <= valid_d;
            last_out_q  <= last_d;
            if (emit) begin
                data_out_q <= key_q[0];
                tag_out_q  <= tag_q[0];
            end
        end
    end

endmodule

// File: tb/tb_stream_sorter_p.sv
// Randomized scoreboard bench for stream_sorter_p. The driver applies words,
// tracks the expected handshake timing, and on each frame close computes the
// sorted frame with a stable sort of (order key, arrival index) pairs and
// queues it; an independent monitor pops and compares every output word.
module tb_stream_sorter_p;
    localparam int DATA_W = 8;
    localparam int TAG_W  = 8;
    localparam int DEPTH  = 256;
    localparam int KMAX   = (1 << DATA_W) - 1;

    typedef logic [DATA_W+TAG_W:0] exp_t;

    logic clk  = 1'b0;
    logic xrst = 1'b0;

    stream_sorter_p_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

    stream_sorter_p #(
        .DATA_W(DATA_W),
        .TAG_W (TAG_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .xrst(xrst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t              sb[$];
    int                check_cnt = 0;
    int                pass_cnt  = 0;
    bit                model_ready = 1'b1;
    int                drain_left  = 0;
    int                cur_f       = 0;
    logic [DATA_W-1:0] frm_keys[$];
    logic [TAG_W-1:0]  frm_tags[$];
    bit                frm_desc;
    logic [DATA_W-1:0] stim_keys[$];
    logic [TAG_W-1:0]  stim_tags[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference: stable sort by order key, ties broken by arrival index.
    task automatic closeFrame();
        int q[$];
        int f;
        f = frm_keys.size();
        for (int i = 0; i < f; i++) begin
            int sk;
            sk = frm_desc ? (KMAX - int'(frm_keys[i])) : int'(frm_keys[i]);
            q.push_back(sk * 65536 + i);
        end
        q.sort();
        for (int j = 0; j < f; j++) begin
            int idx;
            idx = q[j] % 65536;
            sb.push_back({logic'(j == f - 1), frm_keys[idx], frm_tags[idx]});
        end
        model_ready = 1'b0;
        drain_left  = f + 1;
        cur_f       = f;
        frm_keys.delete();
        frm_tags.delete();
    endtask

    task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d, input logic [TAG_W-1:0] t,
                                 input logic l, input logic ds, output bit acc);
        bus.valid_in = v;
        bus.data_in  = d;
        bus.tag_in   = t;
        bus.last_in  = l;
        bus.descend  = ds;
        checkOutput("ready_in", 32'(bus.ready_in), 32'(model_ready));
        checkOutput("valid_out_timing", 32'(bus.valid_out), 32'(!model_ready && drain_left <= cur_f));
        acc = 1'b0;
        if (!model_ready) begin
            drain_left--;
            if (drain_left == 0) model_ready = 1'b1;
        end else if (v) begin
            acc = 1'b1;
            if (frm_keys.size() == 0) frm_desc = ds;
            frm_keys.push_back(d);
            frm_tags.push_back(t);
            if (l || frm_keys.size() == DEPTH) closeFrame();
        end
        @(negedge clk);
    endtask

    task automatic drainFrame(input bit hold_valid);
        bit acc;
        while (!model_ready)
            applyStimulus(hold_valid, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), acc);
        checkOutput("sb_drained", 32'(sb.size()), 32'(0));
    endtask

    task automatic sendFrame(input bit use_last, input int gap_pct, input bit desc0,
                             input bit toggle, input bit hold_valid);
        int n;
        n = stim_keys.size();
        for (int i = 0; i < n; i++) begin
            bit acc;
            logic ds;
            acc = 1'b0;
            ds  = (i == 0) ? desc0 : (toggle ? 1'($urandom) : desc0);
            while (!acc) begin
                if (int'($urandom_range(99)) < gap_pct)
                    applyStimulus(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), acc);
                else
                    applyStimulus(1'b1, stim_keys[i], stim_tags[i], logic'(use_last && i == n - 1), ds, acc);
            end
        end
        bus.valid_in = 1'b0;
        if (!model_ready) drainFrame(hold_valid);
    endtask

    task automatic pulseReset();
        xrst         = 1'b0;
        bus.valid_in = 1'b0;
        #1;
        checkOutput("rst_valid_out", 32'(bus.valid_out), 32'(0));
        checkOutput("rst_last_out", 32'(bus.last_out), 32'(0));
        checkOutput("rst_ready_in", 32'(bus.ready_in), 32'(1));
        checkOutput("rst_data_out", 32'(bus.data_out), 32'(0));
        checkOutput("rst_tag_out", 32'(bus.tag_out), 32'(0));
        sb.delete();
        frm_keys.delete();
        frm_tags.delete();
        model_ready = 1'b1;
        drain_left  = 0;
        cur_f       = 0;
        @(negedge clk);
        xrst = 1'b1;
    endtask

    task automatic randomKeys(input int n, input int kmode);
        stim_keys.delete();
        stim_tags.delete();
        for (int i = 0; i < n; i++) begin
            logic [DATA_W-1:0] k;
            case (kmode)
                1:       k = 8'($urandom_range(3));
                2:       k = $urandom_range(1) ? 8'(KMAX) : 8'd0;
                default: k = 8'($urandom);
            endcase
            stim_keys.push_back(k);
            stim_tags.push_back(8'(i));
        end
    endtask

    // Monitor: every valid output word must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (xrst && bus.valid_out) begin
            if (sb.size() == 0) begin
                check_cnt++;
                $display("[TB] FAIL sb_extra_output: got data 0x%0h with no word expected at %0t", bus.data_out, $time);
            end else begin
                e = sb.pop_front();
                checkOutput("data_out", 32'(bus.data_out), 32'(e[DATA_W+TAG_W-1:TAG_W]));
                checkOutput("tag_out", 32'(bus.tag_out), 32'(e[TAG_W-1:0]));
                checkOutput("last_out", 32'(bus.last_out), 32'(e[DATA_W+TAG_W]));
            end
        end
    end

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation did not finish, checks %0d", check_cnt);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        bus.tag_in   = '0;
        bus.last_in  = 1'b0;
        bus.descend  = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("init_valid_out", 32'(bus.valid_out), 32'(0));
        checkOutput("init_last_out", 32'(bus.last_out), 32'(0));
        checkOutput("init_ready_in", 32'(bus.ready_in), 32'(1));
        checkOutput("init_data_out", 32'(bus.data_out), 32'(0));
        checkOutput("init_tag_out", 32'(bus.tag_out), 32'(0));
        xrst = 1'b1;

        // Full ascending frame, then the same keys descending with toggled descend.
        randomKeys(DEPTH, 0);
        sendFrame(1'b0, 0, 1'b0, 1'b0, 1'b0);
        sendFrame(1'b0, 0, 1'b1, 1'b1, 1'b0);

        // Fixed five-word frame, valid_in held during drain.
        stim_keys = '{8'd9, 8'd3, 8'd7, 8'd3, 8'd1};
        stim_tags = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4};
        sendFrame(1'b1, 0, 1'b0, 1'b0, 1'b1);
        randomKeys(6, 0);
        sendFrame(1'b1, 0, 1'b0, 1'b0, 1'b0);

        // Single-word frame.
        stim_keys = '{8'hAA};
        stim_tags = '{8'h55};
        sendFrame(1'b1, 0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a frame, then a short frame.
        randomKeys(100, 0);
        sendFrame(1'b0, 0, 1'b0, 1'b0, 1'b0);
        pulseReset();
        randomKeys(4, 0);
        sendFrame(1'b1, 0, 1'b0, 1'b0, 1'b0);

        // All-equal keys in descending mode keep arrival order.
        stim_keys.delete();
        stim_tags.delete();
        for (int i = 0; i < 8; i++) begin
            stim_keys.push_back(8'h42);
            stim_tags.push_back(8'(i));
        end
        sendFrame(1'b1, 0, 1'b1, 1'b0, 1'b0);

        // Random short frames with gaps, duplicates and extreme keys.
        for (int r = 0; r < 12; r++) begin
            randomKeys(int'($urandom_range(1, 40)), r % 3);
            sendFrame(1'b1, 30, 1'($urandom), 1'b1, 1'($urandom));
        end

        // last_in on the DEPTH-th word closes exactly once.
        randomKeys(DEPTH, 1);
        sendFrame(1'b1, 10, 1'b1, 1'b0, 1'b0);
        randomKeys(3, 2);
        sendFrame(1'b1, 0, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
